// File: rtl/pip_judge_ctrl.sv
// Round sequencer for the point-in-polygon judge: loads the wall pattern, then
// counts player pixels that land outside the polygon over a fixed number of frames.
module pip_judge_ctrl #(
   parameter int PIP_LAT      = 2,
   parameter int JUDGE_FRAMES = 4,
   parameter int MISS_THRESH  = 16,
   parameter int CNT_W        = 16,
   parameter int LOAD_TMO     = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       pattern_sel,
   input  logic             frame_start,
   input  logic             pix_en,
   input  logic             player_px,
   input  logic             in_polygon,
   input  logic             in_polygon_valid,
   output logic [2:0]       pattern_num,
   output logic             in_polygon_enable,
   output logic             busy,
   output logic             round_done,
   output logic             round_pass,
   output logic             load_err,
   output logic [CNT_W-1:0] miss_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_WAIT_LO = 3'd2,
      S_WAIT_HI = 3'd3,
      S_ARM     = 3'd4,
      S_JUDGE   = 3'd5,
      S_DONE    = 3'd6,
      S_ERR     = 3'd7
   } state_t;

   localparam int               TMR_W    = $clog2(LOAD_TMO + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOAD_TMO - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [3:0]       FRM_LAST = 4'(JUDGE_FRAMES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] MISS_LIM = CNT_W'(MISS_THRESH);

   state_t             state_r;
   logic [PIP_LAT-1:0] pipe_r;
   logic [3:0]         frm_cnt_r;
   logic [TMR_W-1:0]   tmr_r;
   logic               miss_s;
   logic [CNT_W-1:0]   miss_next_s;

   // Miss detection on the latency-aligned player pixel, with a saturating count.
   always_comb begin
      miss_s      = 1'b0;
      miss_next_s = miss_count;
      if ((state_r == S_JUDGE) && pix_en && pipe_r[PIP_LAT-1] && !in_polygon) begin
         miss_s = 1'b1;
      end else begin
         miss_s = 1'b0;
      end
      if (miss_s && (miss_count != CNT_MAX)) begin
         miss_next_s = miss_count + CNT_ONE;
      end else begin
         miss_next_s = miss_count;
      end
   end

   // Round FSM with registered outputs, load timer, frame counter and player delay chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r           <= S_IDLE;
         pipe_r            <= '0;
         frm_cnt_r         <= 4'd0;
         tmr_r             <= '0;
         pattern_num       <= 3'd0;
         in_polygon_enable <= 1'b0;
         busy              <= 1'b0;
         round_done        <= 1'b0;
         round_pass        <= 1'b0;
         load_err          <= 1'b0;
         miss_count        <= '0;
      end else begin
         // Entering JUDGE flushes the chain so pixels seen while armed never count.
         if ((state_r == S_ARM) && frame_start) begin
            pipe_r <= '0;
         end else if (pix_en) begin
            for (int i = PIP_LAT - 1; i > 0; i--) begin
               pipe_r[i] <= pipe_r[i-1];
            end
            pipe_r[0] <= player_px;
         end

         case (state_r)
            S_IDLE: begin
               if (start) begin
                  state_r           <= S_LOAD;
                  pattern_num       <= pattern_sel;
                  miss_count        <= '0;
                  round_pass        <= 1'b0;
                  load_err          <= 1'b0;
                  in_polygon_enable <= 1'b1;
                  busy              <= 1'b1;
               end
            end
            S_LOAD: begin
               in_polygon_enable <= 1'b0;
               tmr_r             <= '0;
               state_r           <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               if (!in_polygon_valid) begin
                  tmr_r   <= '0;
                  state_r <= S_WAIT_HI;
               end else if (tmr_r == TMR_LAST) begin
                  state_r    <= S_ERR;
                  load_err   <= 1'b1;
                  round_pass <= 1'b0;
                  round_done <= 1'b1;
               end else begin
                  tmr_r <= tmr_r + TMR_ONE;
               end
            end
            S_WAIT_HI: begin
               if (in_polygon_valid) begin
                  state_r <= S_ARM;
               end else if (tmr_r == TMR_LAST) begin
                  state_r    <= S_ERR;
                  load_err   <= 1'b1;
                  round_pass <= 1'b0;
                  round_done <= 1'b1;
               end else begin
                  tmr_r <= tmr_r + TMR_ONE;
               end
            end
            S_ARM: begin
               if (frame_start) begin
                  frm_cnt_r <= 4'd0;
                  state_r   <= S_JUDGE;
               end
            end
            S_JUDGE: begin
               miss_count <= miss_next_s;
               if (frame_start) begin
                  if (frm_cnt_r == FRM_LAST) begin
                     state_r    <= S_DONE;
                     round_done <= 1'b1;
                     round_pass <= (miss_next_s < MISS_LIM);
                  end else begin
                     frm_cnt_r <= frm_cnt_r + 4'd1;
                  end
               end
            end
            S_DONE, S_ERR: begin
               round_done <= 1'b0;
               busy       <= 1'b0;
               state_r    <= S_IDLE;
            end
            default: begin
               state_r           <= S_IDLE;
               in_polygon_enable <= 1'b0;
               round_done        <= 1'b0;
               busy              <= 1'b0;
            end
         endcase
      end
   end

endmodule
